bus_master: RTL and testbench



---
 rtl/bus_master.sv | 179 +++++++++++++++++
 tb/tb_bus_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master.sv
// bus_master: burst bus master with a single-request arbiter handshake.
// Accepts a read or write burst command in IDLE, requests the bus, issues
// one beat per granted cycle at consecutive (wrapping) addresses, and returns
// read words two cycles after their address beat, strictly in address order.
module bus_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_wr,
    input  logic [15:0] op_addr,
    input  logic [7:0]  op_len,
    input  logic [63:0] wd_data,
    output logic        wd_pop,
    output logic        rd_valid,
    output logic [63:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        m_req,
    input  logic        m_grant,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    input  logic [63:0] m_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      r_state;

    // Command fields, held for the whole burst so op_* may change freely.
    logic        r_wr;
    logic [7:0]  r_len;

    // r_addr always holds the address of the next beat to issue; r_idx is
    // the number of beats already issued.
    logic [15:0] r_addr;
    logic [7:0]  r_idx;

    // Registered status outputs.
    logic        r_busy;
    logic        r_done;
    logic        r_req;

    // Read return pipeline.
    logic        r_rd_flag;
    logic        r_rd_valid;
    logic [63:0] r_rd_data;

    logic        w_beat;
    logic        w_last;

    // A beat is issued exactly when we own the transfer phase and the
    // arbiter grants in that same cycle.
    assign w_beat = (r_state == S_XFER) && m_grant;
    assign w_last = (r_idx == (r_len - 8'd1));

    // Bus pins: driven only during an issued beat, zero otherwise.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        m_wr   = 1'b0;
        m_addr = 16'h0000;
        m_dout = 64'h0;
        wd_pop = 1'b0;
        if (w_beat) begin
            m_wr   = r_wr;
            m_addr = r_addr;
            wd_pop = r_wr;
            if (r_wr) begin
                m_dout = wd_data;
            end
        end
    end

    // Command FSM: sequencing, beat bookkeeping and registered status.
    // NOTE: state is updated with non-blocking assignments so every register
    // in the block sees the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_len   <= 8'd0;
            r_addr  <= 16'h0000;
            r_idx   <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wr   <= op_wr;
                        r_addr <= op_addr;
                        r_len  <= op_len;
                        r_idx  <= 8'd0;
                        r_busy <= 1'b1;
                        if (op_len == 8'd0) begin
                            // Empty burst: straight to completion, no bus traffic.
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    if (m_grant) begin
                        r_state <= S_XFER;
                    end
                end

                S_XFER: begin
                    if (m_grant) begin
                        r_addr <= r_addr + 16'd1;
                        r_idx  <= r_idx + 8'd1;
                        if (w_last) begin
                            r_req <= 1'b0;
                            if (r_wr) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                // The last read word is still in flight.
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Read return: flag a read beat, capture m_din one cycle later, then
    // present it with rd_valid the cycle after that.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_flag  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 64'h0;
        end else begin
            r_rd_flag  <= w_beat && !r_wr;
            r_rd_valid <= r_rd_flag;
            if (r_rd_flag) begin
                r_rd_data <= m_din;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign m_req    = r_req;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: randomized self-checking bench for bus_master.
// The bench plays arbiter and memory. A transaction-level model predicts,
// cycle by cycle, the bus beats, status outputs and read returns from the
// command, the grant pattern it chose and the memory words it supplied.
module tb_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_wr;
    logic [15:0] op_addr;
    logic [7:0]  op_len;
    logic [63:0] wd_data;
    logic        wd_pop;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        busy;
    logic        done;
    logic        m_req;
    logic        m_grant;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic [63:0] m_din;

    always #5 clk = ~clk;

    bus_master dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op_wr    (op_wr),
        .op_addr  (op_addr),
        .op_len   (op_len),
        .wd_data  (wd_data),
        .wd_pop   (wd_pop),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .m_req    (m_req),
        .m_grant  (m_grant),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .m_din    (m_din)
    );

    typedef enum {P_REQ, P_XFER, P_DRAIN, P_DONE, P_IDLE} phase_t;

    typedef struct {
        int          at;
        logic [63:0] d;
    } rd_exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    rd_exp_t     rd_q[$];
    logic [63:0] rd_words [256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sample all outputs mid-cycle and compare against the model.
    task automatic sample_cycle(input logic e_req, input logic e_busy, input logic e_done,
                                input logic e_wbeat, input logic [15:0] e_addr,
                                input logic [63:0] e_dout);
        logic e_rv;
        @(negedge clk);
        check("m_req",  m_req,  e_req);
        check("busy",   busy,   e_busy);
        check("done",   done,   e_done);
        check("m_wr",   m_wr,   e_wbeat);
        check("wd_pop", wd_pop, e_wbeat);
        check("m_addr", m_addr, e_addr);
        check("m_dout", m_dout, e_dout);
        e_rv = (rd_q.size() > 0) && (rd_q[0].at == cyc);
        check("rd_valid", rd_valid, e_rv);
        if (e_rv) begin
            check("rd_data", rd_data, rd_q[0].d);
            void'(rd_q.pop_front());
        end
        cyc++;
    endtask

    // Run one command. mode: 0 = grant always, 1 = random grant,
    // 2 = grant withheld for two cycles after beat 1. abort_at >= 0 asserts
    // reset during that beat.
    task automatic run_cmd(input bit wr, input logic [15:0] addr, input int len,
                           input int mode, input int abort_at);
        phase_t      ph;
        phase_t      nxt;
        int          k        = 0;
        int          gap_left = 2;
        bit          pend_v   = 1'b0;
        logic [63:0] pend_d   = 64'h0;
        bit          g;
        bit          aborted  = 1'b0;
        logic        e_req, e_busy, e_done, e_wb;
        logic [15:0] e_addr;
        logic [63:0] e_dout;
        rd_exp_t     e;

        @(posedge clk); #1;
        start   = 1'b1;
        op_wr   = wr;
        op_addr = addr;
        op_len  = 8'(len);
        m_grant = 1'($urandom_range(0, 1));
        wd_data = {$urandom, $urandom};
        sample_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
        ph = (len == 0) ? P_DONE : P_REQ;

        while (1) begin
            @(posedge clk); #1;
            if (ph == P_IDLE) begin
                start = 1'b0;
            end else begin
                // Commands presented while busy must be ignored.
                start   = 1'($urandom_range(0, 1));
                op_wr   = 1'($urandom_range(0, 1));
                op_addr = 16'($urandom);
                op_len  = 8'($urandom);
            end
            wd_data = {$urandom, $urandom};
            m_din   = pend_v ? pend_d : {$urandom, $urandom};
            pend_v  = 1'b0;

            case (mode)
                0:       g = 1'b1;
                1:       g = ($urandom_range(0, 3) != 0);
                default: begin
                    if (ph == P_XFER && k == 2 && gap_left > 0) begin
                        g = 1'b0;
                        gap_left--;
                    end else begin
                        g = 1'b1;
                    end
                end
            endcase
            m_grant = g;

            e_req  = 1'b0;
            e_busy = 1'b1;
            e_done = 1'b0;
            e_wb   = 1'b0;
            e_addr = 16'h0;
            e_dout = 64'h0;
            nxt    = ph;
            case (ph)
                P_REQ: begin
                    e_req = 1'b1;
                    if (g) nxt = P_XFER;
                end
                P_XFER: begin
                    e_req = 1'b1;
                    if (g) begin
                        e_addr = addr + 16'(k);
                        if (wr) begin
                            e_wb   = 1'b1;
                            e_dout = wd_data;
                        end else begin
                            pend_v = 1'b1;
                            pend_d = rd_words[k];
                            e.at   = cyc + 2;
                            e.d    = rd_words[k];
                            rd_q.push_back(e);
                        end
                        if (k == abort_at) begin
                            reset   = 1'b1;
                            aborted = 1'b1;
                        end
                        k++;
                        if (k == len) nxt = wr ? P_DONE : P_DRAIN;
                    end
                end
                P_DRAIN: nxt = P_DONE;
                P_DONE: begin
                    e_done = 1'b1;
                    nxt    = P_IDLE;
                end
                default: e_busy = 1'b0;
            endcase

            sample_cycle(e_req, e_busy, e_done, e_wb, e_addr, e_dout);

            if (aborted) begin
                // Anything still in flight is discarded by the reset.
                rd_q.delete();
                for (int i = 0; i < 2; i++) begin
                    @(posedge clk); #1;
                    reset   = 1'b0;
                    start   = 1'b0;
                    m_grant = 1'($urandom_range(0, 1));
                    m_din   = {$urandom, $urandom};
                    sample_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
                    check("rd_data_after_reset", rd_data, 64'h0);
                end
                break;
            end
            if (ph == P_IDLE) break;
            ph = nxt;
        end
    endtask

    initial begin
        bit          wr;
        logic [15:0] addr;
        int          len;
        int          mode;
        int          abort_at;
        int          sel;

        reset   = 1'b1;
        start   = 1'b1;
        op_wr   = 1'b1;
        op_addr = 16'h1234;
        op_len  = 8'd7;
        wd_data = 64'h0;
        m_grant = 1'b1;
        m_din   = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        sample_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
        check("rd_data_reset", rd_data, 64'h0);

        // Write burst, immediate grant.
        run_cmd(1'b1, 16'h0010, 3, 0, -1);

        // Read burst with fixed return words.
        rd_words[0] = 64'hA0A0_A0A0_A0A0_A0A0;
        rd_words[1] = 64'hB0B0_B0B0_B0B0_B0B0;
        run_cmd(1'b0, 16'h0100, 2, 0, -1);

        // Read burst with a two-cycle grant gap after beat 1.
        for (int i = 0; i < 4; i++) rd_words[i] = {$urandom, $urandom};
        run_cmd(1'b0, 16'h2000, 4, 2, -1);

        // Address wrap, both directions.
        run_cmd(1'b1, 16'hFFFE, 3, 0, -1);
        for (int i = 0; i < 3; i++) rd_words[i] = {$urandom, $urandom};
        run_cmd(1'b0, 16'hFFFE, 3, 1, -1);

        // Zero-length command.
        run_cmd(1'b1, 16'h0040, 0, 0, -1);
        run_cmd(1'b0, 16'h0040, 0, 1, -1);

        // Reset during beat 2 of a 5-beat write.
        run_cmd(1'b1, 16'h0300, 5, 0, 2);

        // Reset and start in the same cycle: reset wins.
        @(posedge clk); #1;
        reset   = 1'b1;
        start   = 1'b1;
        op_wr   = 1'b1;
        op_len  = 8'd5;
        m_grant = 1'b1;
        sample_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        sample_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0);

        // Randomized commands.
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                               : 16'($urandom);
            sel  = $urandom_range(0, 19);
            if (sel == 0)       len = 0;
            else if (sel == 19) len = 255;
            else                len = $urandom_range(1, 16);
            mode = $urandom_range(0, 2);
            if (len > 0 && $urandom_range(0, 7) == 0) abort_at = $urandom_range(0, len - 1);
            else                                      abort_at = -1;
            for (int i = 0; i < 256; i++) rd_words[i] = {$urandom, $urandom};
            run_cmd(wr, addr, len, mode, abort_at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
